// File: rtl/gnt_arbiter_if.sv
// Request/grant bundle between requesters (master side) and the grant arbiter (slave side).
interface gnt_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            timeout;

  modport master (output req, input gnt, input gnt_id, input busy, input timeout);
  modport slave  (input req, output gnt, output gnt_id, output busy, output timeout);
endinterface

// File: rtl/gnt_arbiter.sv
// Round-robin arbiter with programmable grant latency and a hold limit that
// force-releases and masks a requester that keeps its grant too long.
module gnt_arbiter #(
  parameter int NREQ     = 4,
  parameter int GNT_LAT  = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  gnt_arbiter_if.slave  bus
);
  localparam int              IDW       = $clog2(NREQ);
  localparam logic [2:0]      WAIT_INIT = (GNT_LAT > 0) ? 3'(GNT_LAT - 1) : 3'd0;
  localparam logic [7:0]      HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [NREQ-1:0] ONE       = NREQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT, S_RELEASE} state_t;

  state_t          state_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [IDW-1:0]  gnt_id_reg;
  logic            busy_reg;
  logic            timeout_reg;
  logic [NREQ-1:0] mask_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [7:0]      hold_reg;
  logic [2:0]      wait_reg;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  idx;
  logic            win_req;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_elig
      assign eligible[gi] = bus.req[gi] & ~mask_reg[gi];
    end
  endgenerate

  // Walk downward so the last hit, i.e. the one closest after ptr, wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(ptr_reg) + k) % NREQ);
      if (eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign win_req = bus.req[gnt_id_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      mask_reg    <= '0;
      ptr_reg     <= IDW'(NREQ - 1);
      hold_reg    <= '0;
      wait_reg    <= '0;
    end else begin
      timeout_reg <= 1'b0;
      mask_reg    <= mask_reg & bus.req;
      case (state_reg)
        S_IDLE: begin
          if (found) begin
            gnt_id_reg <= pick;
            busy_reg   <= 1'b1;
            if (GNT_LAT == 0) begin
              state_reg <= S_GRANT;
              gnt_reg   <= ONE << pick;
              hold_reg  <= 8'd1;
            end else begin
              state_reg <= S_WAIT;
              wait_reg  <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!win_req) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else if (wait_reg == 3'd0) begin
            state_reg <= S_GRANT;
            gnt_reg   <= ONE << gnt_id_reg;
            hold_reg  <= 8'd1;
          end else begin
            wait_reg <= wait_reg - 3'd1;
          end
        end
        S_GRANT: begin
          // A voluntary drop takes precedence over the hold limit.
          if (!win_req) begin
            state_reg <= S_RELEASE;
            gnt_reg   <= '0;
          end else if (hold_reg == HOLD_MAX) begin
            state_reg   <= S_RELEASE;
            gnt_reg     <= '0;
            timeout_reg <= 1'b1;
            mask_reg    <= (mask_reg & bus.req) | (ONE << gnt_id_reg);
          end else begin
            hold_reg <= hold_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          ptr_reg   <= gnt_id_reg;
          hold_reg  <= '0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.gnt_id  = gnt_id_reg;
  assign bus.busy    = busy_reg;
  assign bus.timeout = timeout_reg;
endmodule
